ysyx_lsu_sq: RTL and testbench

Committed-store queue between the issue/commit side (iqu_lsu_if producer) and the LSU memory port (store half of lsu_bus_if, master side).
- Buffers retired stores in a circular FIFO.
- Converts size and address into byte strobes and lane-aligned data.
- Drains stores to the bus one at a time with a valid/ready handshake.
- Reports load-address conflicts to the load path, and reports empty status for fence_i and fence drain.

---
 rtl/ysyx_lsu_sq_pkg.sv | 37 +++
 rtl/ysyx_lsu_sq_align.sv | 43 ++++
 rtl/ysyx_lsu_sq.sv | 179 +++++++++++++++++
 tb/tb_ysyx_lsu_sq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_lsu_sq_pkg.sv
// ysyx_lsu_sq_pkg: shared types and sizing for the committed-store queue.
//   SQ_XLEN     - data/address width (32)
//   SQ_DEPTH    - default queue depth
//   SQ_PTR_W    - head/tail pointer width for the default depth (index + wrap bit)
//   sq_size_e   - store size encoding (matches iqu_lsu.alu[1:0])
//   sq_entry_t  - one queued store: address, raw data, size
// Optional feature macro used by the queue: YSYX_SQ_FORWARD_EN.
package ysyx_lsu_sq_pkg;

    localparam int unsigned SQ_XLEN = 32;

    localparam int unsigned SQ_DEPTH = 4;
    localparam int unsigned SQ_PTR_W = $clog2(SQ_DEPTH) + 1;

    typedef enum logic [1:0] {
        SQ_SB = 2'b00,
        SQ_SH = 2'b01,
        SQ_SW = 2'b10
    } sq_size_e;

    typedef enum logic {
        SQ_IDLE = 1'b0,
        SQ_BUSY = 1'b1
    } sq_state_e;

    typedef struct packed {
        logic [SQ_XLEN-1:0] addr;
        logic [SQ_XLEN-1:0] data;
        sq_size_e           size;
    } sq_entry_t;

    // The illegal encoding 2'b11 is folded onto SW.
    function automatic sq_size_e sq_decode_size(input logic [1:0] raw);
        return (raw == 2'b11) ? SQ_SW : sq_size_e'(raw);
    endfunction

endpackage

// File: rtl/ysyx_lsu_sq_align.sv
// ysyx_lsu_sq_align: combinational store lane aligner.
//   size_i  - store size (SB/SH/SW)
//   data_i  - unaligned store data in the LSBs
//   off_i   - byte offset inside the word (addr[1:0])
//   strb_o  - 4-bit byte strobe
//   data_o  - data shifted onto its byte lanes
module ysyx_lsu_sq_align
    import ysyx_lsu_sq_pkg::*;
#(
    parameter int unsigned XLEN = SQ_XLEN
) (
    input  sq_size_e        size_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      off_i,
    output logic [3:0]      strb_o,
    output logic [XLEN-1:0] data_o
);

    logic [4:0] shamt;

    assign shamt = {off_i, 3'b000};

    // Narrow stores are masked to their width before shifting so upper junk never reaches the bus.
    always_comb begin
        strb_o = 4'hF;
        data_o = data_i;
        case (size_i)
            SQ_SB: begin
                strb_o = 4'b0001 << off_i;
                data_o = XLEN'(data_i[7:0]) << shamt;
            end
            SQ_SH: begin
                strb_o = 4'b0011 << off_i;
                data_o = XLEN'(data_i[15:0]) << shamt;
            end
            default: begin
                strb_o = 4'hF;
                data_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_lsu_sq.sv
// ysyx_lsu_sq: committed-store queue between the commit side and the LSU store port.
//   clock, reset               - core clock, synchronous active-high reset
//   in_valid/in_store/in_alu   - commit slot; alu[1:0] is the store size
//   in_waddr/in_wdata          - store byte address and unaligned data
//   sq_ready                   - a slot is free this cycle
//   sq_empty                   - no queued or in-flight store (fence/fence_i drain)
//   awvalid/awaddr/wvalid/
//   wdata/wstrb/wready         - store half of the LSU bus (master side)
//   ld_araddr/ld_stall         - load conflict check against queued stores
//   ld_hit/ld_rdata            - store-to-load forwarding (YSYX_SQ_FORWARD_EN only)
// Optional feature macro: YSYX_SQ_FORWARD_EN.
module ysyx_lsu_sq
    import ysyx_lsu_sq_pkg::*;
#(
    parameter int unsigned SQ_SIZE = SQ_DEPTH,
    parameter int unsigned XLEN    = SQ_XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_store,
    input  logic [4:0]      in_alu,
    input  logic [XLEN-1:0] in_waddr,
    input  logic [XLEN-1:0] in_wdata,
    output logic            sq_ready,
    output logic            sq_empty,
    output logic            awvalid,
    output logic [XLEN-1:0] awaddr,
    output logic            wvalid,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb,
    input  logic            wready,
    input  logic [XLEN-1:0] ld_araddr,
    output logic            ld_stall,
    output logic            ld_hit,
    output logic [XLEN-1:0] ld_rdata
);

    localparam int unsigned IDX_W = $clog2(SQ_SIZE);
    localparam int unsigned PTR_W = IDX_W + 1;

    sq_entry_t              mem_q [SQ_SIZE];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    sq_state_e              state_q;
    logic                   awvalid_q;
    logic [XLEN-1:0]        awaddr_q;
    logic [XLEN-1:0]        wdata_q;
    logic [3:0]             wstrb_q;

    logic                   empty, full, push, pop;
    logic [PTR_W-1:0]       count;
    sq_entry_t              head_entry, in_entry;
    logic [3:0]             head_strb;
    logic [XLEN-1:0]        head_data;

    logic                   match_any;
    logic                   young_sw;
    logic [XLEN-1:0]        young_data;
    logic [IDX_W-1:0]       scan_idx;
    logic                   unused_bits;

    assign unused_bits = ^{in_alu[4:2], ld_araddr[1:0]};

    // Pointer status comes only from registered pointers, so a same-cycle pop never frees a slot.
    assign empty = (head_q == tail_q);
    assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign count = tail_q - head_q;
    assign push  = in_valid && in_store && !full;
    assign pop   = (state_q == SQ_BUSY) && wready;

    assign tail_d = push ? tail_q + PTR_W'(1) : tail_q;
    assign head_d = pop  ? head_q + PTR_W'(1) : head_q;

    assign in_entry.addr = in_waddr;
    assign in_entry.data = in_wdata;
    assign in_entry.size = sq_decode_size(in_alu[1:0]);

    assign head_entry = mem_q[head_q[IDX_W-1:0]];

    ysyx_lsu_sq_align #(
        .XLEN (XLEN)
    ) u_align (
        .size_i (head_entry.size),
        .data_i (head_entry.data),
        .off_i  (head_entry.addr[1:0]),
        .strb_o (head_strb),
        .data_o (head_data)
    );

    // Entry storage needs no reset: only slots between head and tail are ever read as valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[tail_q[IDX_W-1:0]] <= in_entry;
        end
    end

    // Pointers and drain FSM; the head entry stays in the queue until the bus accepts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            state_q   <= SQ_IDLE;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            case (state_q)
                SQ_IDLE: begin
                    if (!empty) begin
                        awaddr_q  <= {head_entry.addr[XLEN-1:2], 2'b00};
                        wdata_q   <= head_data;
                        wstrb_q   <= head_strb;
                        awvalid_q <= 1'b1;
                        state_q   <= SQ_BUSY;
                    end
                end
                SQ_BUSY: begin
                    if (wready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= SQ_IDLE;
                    end
                end
                default: begin
                    awvalid_q <= 1'b0;
                    state_q   <= SQ_IDLE;
                end
            endcase
        end
    end

    assign sq_ready = !full;
    assign sq_empty = empty && (state_q == SQ_IDLE);
    assign awvalid  = awvalid_q;
    assign wvalid   = awvalid_q;
    assign awaddr   = awaddr_q;
    assign wdata    = wdata_q;
    assign wstrb    = {4'b0000, wstrb_q};

    // Scan oldest to youngest so the last match seen is the youngest matching store.
    always_comb begin
        match_any  = 1'b0;
        young_sw   = 1'b0;
        young_data = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < SQ_SIZE; k++) begin
            scan_idx = head_q[IDX_W-1:0] + IDX_W'(k);
            if ((PTR_W'(k) < count) &&
                (mem_q[scan_idx].addr[XLEN-1:2] == ld_araddr[XLEN-1:2])) begin
                match_any  = 1'b1;
                young_sw   = (mem_q[scan_idx].size == SQ_SW);
                young_data = mem_q[scan_idx].data;
            end
        end
    end

`ifdef YSYX_SQ_FORWARD_EN
    // Only a full-word youngest store can satisfy the load; anything narrower must wait.
    assign ld_hit   = match_any && young_sw;
    assign ld_rdata = (match_any && young_sw) ? young_data : '0;
    assign ld_stall = match_any && !young_sw;
`else
    logic unused_fwd;
    assign unused_fwd = ^{young_sw, young_data};
    assign ld_hit     = 1'b0;
    assign ld_rdata   = '0;
    assign ld_stall   = match_any;
`endif

    a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
        !(in_valid && in_store && full));

    a_legal_size: assert property (@(posedge clock) disable iff (reset)
        !(in_valid && in_store && !full && (in_alu[1:0] == 2'b11)));

endmodule

// File: tb/tb_ysyx_lsu_sq.sv
module tb_ysyx_lsu_sq;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_store;
    logic [4:0]  in_alu;
    logic [31:0] in_waddr, in_wdata;
    logic        sq_ready, sq_empty;
    logic        awvalid, wvalid, wready;
    logic [31:0] awaddr, wdata;
    logic [7:0]  wstrb;
    logic [31:0] ld_araddr;
    logic        ld_stall, ld_hit;
    logic [31:0] ld_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    ysyx_lsu_sq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_store  (in_store),
        .in_alu    (in_alu),
        .in_waddr  (in_waddr),
        .in_wdata  (in_wdata),
        .sq_ready  (sq_ready),
        .sq_empty  (sq_empty),
        .awvalid   (awvalid),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wready    (wready),
        .ld_araddr (ld_araddr),
        .ld_stall  (ld_stall),
        .ld_hit    (ld_hit),
        .ld_rdata  (ld_rdata)
    );

    task automatic tick();
        @(negedge clock);
    endtask

    // Presents one store for one cycle; returns at the negedge after it was captured.
    task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        in_valid = 1'b1; in_store = 1'b1; in_alu = {3'b000, sz}; in_waddr = a; in_wdata = d;
        tick();
        in_valid = 1'b0; in_store = 1'b0;
    endtask

    task automatic drain(input string nm);
        wready = 1'b1;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            if (awvalid) begin
                checks++;
                if (awaddr !== exp_q[0].a || wdata !== exp_q[0].d) begin
                    errors++;
                    $display("FAIL %s order: got addr %h data %h, want addr %h data %h", nm, awaddr, wdata, exp_q[0].a, exp_q[0].d);
                end
                void'(exp_q.pop_front());
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain timeout: %0d stores left, want 0", nm, exp_q.size());
            exp_q.delete();
        end
        tick();
        wready = 1'b0;
        checks++;
        if (sq_empty !== 1'b1) begin errors++; $display("FAIL %s empty after drain: got %b want 1", nm, sq_empty); end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_store = 1'b0; in_alu = '0; in_waddr = '0; in_wdata = '0;
        wready = 1'b0; ld_araddr = 32'hFFFF_FFF0;
        repeat (2) tick();
        checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL reset awvalid: got %b want 0", awvalid); end
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset wvalid: got %b want 0", wvalid); end
        checks++; if (awaddr !== 32'h0 || wdata !== 32'h0) begin errors++; $display("FAIL reset bus: got %h/%h want 0/0", awaddr, wdata); end
        checks++; if (wstrb !== 8'h00) begin errors++; $display("FAIL reset wstrb: got %h want 00", wstrb); end
        checks++; if (sq_ready !== 1'b1 || sq_empty !== 1'b1) begin errors++; $display("FAIL reset status: ready %b empty %b want 1 1", sq_ready, sq_empty); end
        checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0) begin errors++; $display("FAIL reset load: hit %b stall %b want 0 0", ld_hit, ld_stall); end
        reset = 1'b0;
        tick();
        checks++; if (sq_empty !== 1'b1 || awvalid !== 1'b0) begin errors++; $display("FAIL post-reset idle: empty %b awvalid %b want 1 0", sq_empty, awvalid); end
    endtask

    task automatic test_single(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                               input logic [31:0] ea, input logic [31:0] ed, input logic [7:0] es);
        wready = 1'b1;
        push_one(a, d, sz);
        checks++; if (awvalid !== 1'b0 || sq_empty !== 1'b0) begin errors++; $display("FAIL %s t+1: awvalid %b empty %b want 0 0", nm, awvalid, sq_empty); end
        tick();
        checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin errors++; $display("FAIL %s t+2 valid: aw %b w %b want 1 1", nm, awvalid, wvalid); end
        checks++; if (awaddr !== ea) begin errors++; $display("FAIL %s awaddr: got %h want %h", nm, awaddr, ea); end
        checks++; if (wstrb !== es) begin errors++; $display("FAIL %s wstrb: got %h want %h", nm, wstrb, es); end
        checks++; if (wdata !== ed) begin errors++; $display("FAIL %s wdata: got %h want %h", nm, wdata, ed); end
        tick();
        checks++; if (awvalid !== 1'b0 || sq_empty !== 1'b1) begin errors++; $display("FAIL %s t+3: awvalid %b empty %b want 0 1", nm, awvalid, sq_empty); end
        wready = 1'b0;
    endtask

    task automatic test_full();
        wready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
        checks++; if (sq_ready !== 1'b0) begin errors++; $display("FAIL full ready: got %b want 0", sq_ready); end
        checks++; if (awvalid !== 1'b1 || awaddr !== 32'h200 || wdata !== 32'hA0) begin errors++; $display("FAIL full head: aw %b addr %h data %h want 1 200 a0", awvalid, awaddr, wdata); end
        repeat (2) tick();
        checks++; if (awvalid !== 1'b1 || awaddr !== 32'h200 || sq_ready !== 1'b0) begin errors++; $display("FAIL full hold: aw %b addr %h ready %b want 1 200 0", awvalid, awaddr, sq_ready); end
        wready = 1'b1;
        tick();
        wready = 1'b0;
        checks++; if (awvalid !== 1'b0 || sq_ready !== 1'b1) begin errors++; $display("FAIL full pop: aw %b ready %b want 0 1", awvalid, sq_ready); end
        for (int i = 1; i < 4; i++) exp_q.push_back('{a: 32'h200 + 32'(4 * i), d: 32'hA0 + 32'(i)});
        drain("full");
    endtask

    task automatic test_back_to_back();
        wready = 1'b0;
        push_one(32'h300, 32'hB0, 2'b10);
        push_one(32'h304, 32'hB1, 2'b10);
        checks++; if (awvalid !== 1'b1 || awaddr !== 32'h300) begin errors++; $display("FAIL pushpop head: aw %b addr %h want 1 300", awvalid, awaddr); end
        wready = 1'b1;
        push_one(32'h308, 32'hB2, 2'b10);
        wready = 1'b0;
        push_one(32'h30C, 32'hB3, 2'b10);
        checks++; if (sq_ready !== 1'b1) begin errors++; $display("FAIL pushpop count3 ready: got %b want 1", sq_ready); end
        push_one(32'h310, 32'hB4, 2'b10);
        checks++; if (sq_ready !== 1'b0) begin errors++; $display("FAIL pushpop count4 ready: got %b want 0", sq_ready); end
        for (int i = 1; i < 5; i++) exp_q.push_back('{a: 32'h300 + 32'(4 * i), d: 32'hB0 + 32'(i)});
        drain("pushpop");
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        wready = 1'b1;
        for (int cyc = 0; cyc < 100 && popped < 10; cyc++) begin
            if (awvalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL wrap extra store: addr %h, want none", awaddr);
                end else begin
                    if (awaddr !== exp_q[0].a || wdata !== exp_q[0].d) begin
                        errors++; $display("FAIL wrap order: got %h/%h want %h/%h", awaddr, wdata, exp_q[0].a, exp_q[0].d);
                    end
                    void'(exp_q.pop_front());
                end
                popped++;
            end
            if ((cyc % 2 == 0) && pushed < 10 && sq_ready) begin
                in_valid = 1'b1; in_store = 1'b1; in_alu = 5'd2;
                in_waddr = 32'h1000 + 32'(4 * pushed); in_wdata = 32'hC0DE_0000 + 32'(pushed);
                exp_q.push_back('{a: in_waddr, d: in_wdata});
                pushed++;
            end else begin
                in_valid = 1'b0; in_store = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0; in_store = 1'b0;
        checks++; if (popped != 10 || pushed != 10) begin errors++; $display("FAIL wrap count: pushed %0d popped %0d want 10 10", pushed, popped); end
        exp_q.delete();
        tick();
        wready = 1'b0;
        checks++; if (sq_empty !== 1'b1) begin errors++; $display("FAIL wrap empty: got %b want 1", sq_empty); end
    endtask

    task automatic test_conflict();
        wready = 1'b0;
        ld_araddr = 32'h102;
        push_one(32'h100, 32'h11, 2'b00);
        checks++; if (ld_stall !== 1'b1) begin errors++; $display("FAIL conflict queued: stall %b want 1", ld_stall); end
        tick();
        checks++; if (ld_stall !== 1'b1 || awvalid !== 1'b1) begin errors++; $display("FAIL conflict inflight: stall %b aw %b want 1 1", ld_stall, awvalid); end
        ld_araddr = 32'h104; #1;
        checks++; if (ld_stall !== 1'b0 || ld_hit !== 1'b0) begin errors++; $display("FAIL conflict other word: stall %b hit %b want 0 0", ld_stall, ld_hit); end
        ld_araddr = 32'h100; #1;
        checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin errors++; $display("FAIL conflict sb: stall %b hit %b want 1 0", ld_stall, ld_hit); end
        tick();
        push_one(32'h100, 32'h55AA, 2'b10);
`ifdef YSYX_SQ_FORWARD_EN
        checks++; if (ld_hit !== 1'b1 || ld_rdata !== 32'h55AA || ld_stall !== 1'b0) begin errors++; $display("FAIL forward sw: hit %b data %h stall %b want 1 000055aa 0", ld_hit, ld_rdata, ld_stall); end
`else
        checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0 || ld_rdata !== 32'h0) begin errors++; $display("FAIL nofwd sw: stall %b hit %b data %h want 1 0 0", ld_stall, ld_hit, ld_rdata); end
`endif
        push_one(32'h101, 32'h77, 2'b00);
        checks++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0) begin errors++; $display("FAIL youngest sb: stall %b hit %b want 1 0", ld_stall, ld_hit); end
        exp_q.push_back('{a: 32'h100, d: 32'h0000_0011});
        exp_q.push_back('{a: 32'h100, d: 32'h0000_55AA});
        exp_q.push_back('{a: 32'h100, d: 32'h0000_7700});
        drain("conflict");
        checks++; if (ld_stall !== 1'b0 || ld_hit !== 1'b0) begin errors++; $display("FAIL conflict drained: stall %b hit %b want 0 0", ld_stall, ld_hit); end
        ld_araddr = 32'hFFFF_FFF0;
    endtask

    task automatic test_reset_busy();
        wready = 1'b0;
        push_one(32'h400, 32'hD0, 2'b10);
        push_one(32'h404, 32'hD1, 2'b10);
        push_one(32'h408, 32'hD2, 2'b10);
        checks++; if (awvalid !== 1'b1 || sq_empty !== 1'b0) begin errors++; $display("FAIL rstbusy pre: aw %b empty %b want 1 0", awvalid, sq_empty); end
        ld_araddr = 32'h404;
        reset = 1'b1;
        tick();
        checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL rstbusy valid: aw %b w %b want 0 0", awvalid, wvalid); end
        checks++; if (sq_empty !== 1'b1 || sq_ready !== 1'b1) begin errors++; $display("FAIL rstbusy status: empty %b ready %b want 1 1", sq_empty, sq_ready); end
        checks++; if (ld_stall !== 1'b0 || wstrb !== 8'h00) begin errors++; $display("FAIL rstbusy clear: stall %b wstrb %h want 0 00", ld_stall, wstrb); end
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (awvalid !== 1'b0 || sq_empty !== 1'b1) begin errors++; $display("FAIL rstbusy after: aw %b empty %b want 0 1", awvalid, sq_empty); end
        ld_araddr = 32'hFFFF_FFF0;
    endtask

    initial begin
        test_reset();
        test_single("sb_off3", 32'h8000_0003, 32'h0000_00AB, 2'b00, 32'h8000_0000, 32'hAB00_0000, 8'h08);
        test_single("sh_off2", 32'h8000_0002, 32'h0000_1234, 2'b01, 32'h8000_0000, 32'h1234_0000, 8'h0C);
        test_single("sw",      32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F);
        test_single("sb_off1", 32'h8000_0021, 32'hCAFE_115A, 2'b00, 32'h8000_0020, 32'h0000_5A00, 8'h02);
        test_single("sh_off0", 32'h8000_0030, 32'hFFFF_8765, 2'b01, 32'h8000_0030, 32'h0000_8765, 8'h03);
        test_full();
        test_back_to_back();
        test_wrap();
        test_conflict();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
